// File: rtl/gpu_decode_cmd_stage.sv
`default_nettype none
// ============================================================================
// gpu_decode_cmd_stage -- GPU ISA decode with in-place register-file ops and a
// one-entry primitive command output register. Optional: GPU_DECODE_PERF_EN.
// Revision: 1.0
// ============================================================================
module gpu_decode_cmd_stage #(
  parameter int INT_REGS = 8,
  parameter int FP_REGS  = 8,
  parameter int VEC_REGS = 64,
  parameter int LANE_W   = 16,
  parameter int VCNT_W   = 8
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [31:0]         INSTR,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [1:0]          OUT_CMD,
  output logic [2*LANE_W-1:0] OUT_DATA,
  output logic [3:0]          OUT_PTYPE,
  output logic                PRIM_ACTIVE,
  output logic [VCNT_W-1:0]   VERTEX_COUNT,
  output logic [3:0]          ERR
`ifdef GPU_DECODE_PERF_EN
  ,
  output logic [31:0]         STALL_CYCLES,
  output logic [31:0]         CMD_COUNT
`endif
);

  localparam int c_IW = $clog2(INT_REGS);
  localparam int c_FW = $clog2(FP_REGS);
  localparam int c_VW = $clog2(VEC_REGS);

  localparam logic [7:0] c_OP_ADD       = 8'h01;
  localparam logic [7:0] c_OP_SUB       = 8'h02;
  localparam logic [7:0] c_OP_ADDI      = 8'h03;
  localparam logic [7:0] c_OP_SUBI      = 8'h04;
  localparam logic [7:0] c_OP_FADD      = 8'h05;
  localparam logic [7:0] c_OP_FSUB      = 8'h06;
  localparam logic [7:0] c_OP_FADDI     = 8'h07;
  localparam logic [7:0] c_OP_FSUBI     = 8'h08;
  localparam logic [7:0] c_OP_MOV       = 8'h09;
  localparam logic [7:0] c_OP_MOVI      = 8'h0A;
  localparam logic [7:0] c_OP_MOVI_F    = 8'h0B;
  localparam logic [7:0] c_OP_VMOV      = 8'h0C;
  localparam logic [7:0] c_OP_VMOVI     = 8'h0D;
  localparam logic [7:0] c_OP_VCOMPMOV  = 8'h0E;
  localparam logic [7:0] c_OP_VCOMPMOVI = 8'h0F;
  localparam logic [7:0] c_OP_STARTPRIM = 8'h10;
  localparam logic [7:0] c_OP_ENDPRIM   = 8'h11;
  localparam logic [7:0] c_OP_SETVERTEX = 8'h12;
  localparam logic [7:0] c_OP_DRAW      = 8'h13;
  localparam logic [7:0] c_OP_NOP_LO    = 8'h20;
  localparam logic [7:0] c_OP_NOP_HI    = 8'h29;

  localparam logic [1:0] c_CMD_VERTEX = 2'd0;
  localparam logic [1:0] c_CMD_START  = 2'd1;
  localparam logic [1:0] c_CMD_END    = 2'd2;
  localparam logic [1:0] c_CMD_DRAW   = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_PRIM = 1'b1} state_t;

  state_t                r_state;
  logic                  r_out_valid;
  logic [1:0]            r_cmd;
  logic [2*LANE_W-1:0]   r_data;
  logic [3:0]            r_ptype;
  logic [VCNT_W-1:0]     r_vcount;
  logic [3:0]            r_err;

  logic [LANE_W-1:0]     r_ireg [INT_REGS];
  logic [LANE_W-1:0]     r_freg [FP_REGS];
  logic [4*LANE_W-1:0]   r_vreg [VEC_REGS];

  // Field layout: Rd/Fd[23:20] Ra/Fa[19:16] Rb/Fb[15:12] imm[15:0];
  // vector: lane[23:22] Vd[21:16] Vs[13:8] fp-src-sel[15] src[11:8]; ptype[19:16].
  logic [7:0]            w_op;
  logic [c_IW-1:0]       w_rd, w_ra, w_rb, w_rcs;
  logic [c_FW-1:0]       w_fd, w_fa, w_fb, w_fcs;
  logic [c_VW-1:0]       w_vd, w_vs;
  logic [1:0]            w_lane;
  logic [LANE_W-1:0]     w_imm, w_csrc;
  logic                  w_acc;

  assign w_op   = INSTR[31:24];
  assign w_rd   = INSTR[20 +: c_IW];
  assign w_ra   = INSTR[16 +: c_IW];
  assign w_rb   = INSTR[12 +: c_IW];
  assign w_rcs  = INSTR[8 +: c_IW];
  assign w_fd   = INSTR[20 +: c_FW];
  assign w_fa   = INSTR[16 +: c_FW];
  assign w_fb   = INSTR[12 +: c_FW];
  assign w_fcs  = INSTR[8 +: c_FW];
  assign w_vd   = INSTR[16 +: c_VW];
  assign w_vs   = INSTR[8 +: c_VW];
  assign w_lane = INSTR[23:22];
  assign w_imm  = LANE_W'(INSTR[15:0]);
  assign w_csrc = INSTR[15] ? r_freg[w_fcs] : r_ireg[w_rcs];

  assign IN_READY = !r_out_valid || OUT_READY;
  assign w_acc    = IN_VALID && IN_READY;

  logic                  w_iwe, w_fwe, w_vwe;
  logic [LANE_W-1:0]     w_iwd, w_fwd;
  logic [4*LANE_W-1:0]   w_vwd;
  logic                  w_cmd_load;
  logic [1:0]            w_cmd;
  logic [2*LANE_W-1:0]   w_data;
  logic [3:0]            w_ptype;
  logic [3:0]            w_err_set;

  always_comb begin
    w_iwe      = 1'b0;
    w_fwe      = 1'b0;
    w_vwe      = 1'b0;
    w_iwd      = '0;
    w_fwd      = '0;
    w_vwd      = '0;
    w_cmd_load = 1'b0;
    w_cmd      = c_CMD_VERTEX;
    w_data     = '0;
    w_ptype    = '0;
    w_err_set  = '0;
    case (w_op)
      c_OP_ADD:    begin w_iwe = 1'b1; w_iwd = r_ireg[w_ra] + r_ireg[w_rb]; end
      c_OP_SUB:    begin w_iwe = 1'b1; w_iwd = r_ireg[w_ra] - r_ireg[w_rb]; end
      c_OP_ADDI:   begin w_iwe = 1'b1; w_iwd = r_ireg[w_ra] + w_imm; end
      c_OP_SUBI:   begin w_iwe = 1'b1; w_iwd = r_ireg[w_ra] - w_imm; end
      c_OP_FADD:   begin w_fwe = 1'b1; w_fwd = r_freg[w_fa] + r_freg[w_fb]; end
      c_OP_FSUB:   begin w_fwe = 1'b1; w_fwd = r_freg[w_fa] - r_freg[w_fb]; end
      c_OP_FADDI:  begin w_fwe = 1'b1; w_fwd = r_freg[w_fa] + w_imm; end
      c_OP_FSUBI:  begin w_fwe = 1'b1; w_fwd = r_freg[w_fa] - w_imm; end
      c_OP_MOV:    begin w_iwe = 1'b1; w_iwd = r_ireg[w_ra]; end
      c_OP_MOVI:   begin w_iwe = 1'b1; w_iwd = w_imm; end
      c_OP_MOVI_F: begin w_fwe = 1'b1; w_fwd = w_imm; end
      c_OP_VMOV:   begin w_vwe = 1'b1; w_vwd = r_vreg[w_vs]; end
      c_OP_VMOVI:  begin w_vwe = 1'b1; w_vwd = {4{w_imm}}; end
      c_OP_VCOMPMOV, c_OP_VCOMPMOVI: begin
        w_vwe = 1'b1;
        w_vwd = r_vreg[w_vd];
        for (int l = 0; l < 4; l++) begin
          if (w_lane == 2'(l))
            w_vwd[l*LANE_W +: LANE_W] = (w_op == c_OP_VCOMPMOVI) ? w_imm : w_csrc;
        end
      end
      c_OP_STARTPRIM: begin
        if (r_state == S_PRIM) w_err_set[0] = 1'b1;
        else begin
          w_cmd_load = 1'b1;
          w_cmd      = c_CMD_START;
          w_ptype    = INSTR[19:16];
        end
      end
      c_OP_ENDPRIM: begin
        if (r_state == S_IDLE) w_err_set[1] = 1'b1;
        else begin
          w_cmd_load = 1'b1;
          w_cmd      = c_CMD_END;
        end
      end
      c_OP_SETVERTEX: begin
        if (r_state == S_IDLE) w_err_set[2] = 1'b1;
        else begin
          w_cmd_load = 1'b1;
          w_cmd      = c_CMD_VERTEX;
          w_data     = r_vreg[w_vd][3*LANE_W-1:LANE_W];
        end
      end
      c_OP_DRAW: begin
        w_cmd_load = 1'b1;
        w_cmd      = c_CMD_DRAW;
      end
      default: begin
        if (w_op < c_OP_NOP_LO || w_op > c_OP_NOP_HI) w_err_set[3] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < INT_REGS; i++) r_ireg[i] <= '0;
      for (int i = 0; i < FP_REGS; i++)  r_freg[i] <= '0;
      for (int i = 0; i < VEC_REGS; i++) r_vreg[i] <= '0;
    end else if (w_acc) begin
      if (w_iwe) r_ireg[w_rd] <= w_iwd;
      if (w_fwe) r_freg[w_fd] <= w_fwd;
      if (w_vwe) r_vreg[w_vd] <= w_vwd;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_cmd       <= '0;
      r_data      <= '0;
      r_ptype     <= '0;
      r_vcount    <= '0;
      r_err       <= '0;
    end else begin
      if (w_acc && w_cmd_load) begin
        r_out_valid <= 1'b1;
        r_cmd       <= w_cmd;
        r_data      <= w_data;
        r_ptype     <= w_ptype;
      end else if (OUT_READY) begin
        r_out_valid <= 1'b0;
      end
      if (w_acc) begin
        r_err <= r_err | w_err_set;
        if (w_cmd_load) begin
          case (w_cmd)
            c_CMD_START: begin
              r_state  <= S_PRIM;
              r_vcount <= '0;
            end
            c_CMD_END:   r_state <= S_IDLE;
            c_CMD_VERTEX: begin
              if (r_vcount != '1) r_vcount <= r_vcount + VCNT_W'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign OUT_VALID    = r_out_valid;
  assign OUT_CMD      = r_cmd;
  assign OUT_DATA     = r_data;
  assign OUT_PTYPE    = r_ptype;
  assign PRIM_ACTIVE  = (r_state == S_PRIM);
  assign VERTEX_COUNT = r_vcount;
  assign ERR          = r_err;

`ifdef GPU_DECODE_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_cmd_count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall_cycles <= '0;
      r_cmd_count    <= '0;
    end else begin
      if (IN_VALID && !IN_READY) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (r_out_valid && OUT_READY) r_cmd_count <= r_cmd_count + 32'd1;
    end
  end

  assign STALL_CYCLES = r_stall_cycles;
  assign CMD_COUNT    = r_cmd_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpu_decode_cmd_stage.sv
`default_nettype none
// ============================================================================
// tb_gpu_decode_cmd_stage -- directed table, corner sequences and randomized
// stimulus against a queue-based reference model. Revision: 1.0
// ============================================================================
module tb_gpu_decode_cmd_stage;

  localparam int INT_REGS = 8;
  localparam int FP_REGS  = 8;
  localparam int VEC_REGS = 64;

  logic        CLK, RESET_N, IN_VALID, IN_READY, OUT_VALID, OUT_READY, PRIM_ACTIVE;
  logic [31:0] INSTR, OUT_DATA;
  logic [1:0]  OUT_CMD;
  logic [3:0]  OUT_PTYPE, ERR;
  logic [7:0]  VERTEX_COUNT;
`ifdef GPU_DECODE_PERF_EN
  logic [31:0] STALL_CYCLES, CMD_COUNT;
`endif

  gpu_decode_cmd_stage dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR(INSTR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_CMD(OUT_CMD), .OUT_DATA(OUT_DATA), .OUT_PTYPE(OUT_PTYPE),
    .PRIM_ACTIVE(PRIM_ACTIVE), .VERTEX_COUNT(VERTEX_COUNT), .ERR(ERR)
`ifdef GPU_DECODE_PERF_EN
    , .STALL_CYCLES(STALL_CYCLES), .CMD_COUNT(CMD_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] i_rri(input logic [7:0] op, input logic [3:0] d,
                                        input logic [3:0] a, input logic [15:0] imm);
    return {op, d, a, imm};
  endfunction
  function automatic logic [31:0] i_vi(input logic [7:0] op, input logic [1:0] lane,
                                       input logic [5:0] v, input logic [15:0] imm);
    return {op, lane, v, imm};
  endfunction
  function automatic logic [31:0] i_vr(input logic [7:0] op, input logic [1:0] lane,
                                       input logic [5:0] v, input logic fp, input logic [3:0] s);
    return {op, lane, v, fp, 3'b000, s, 8'h00};
  endfunction
  function automatic logic [31:0] i_start(input logic [3:0] pt);
    return {8'h10, 4'h0, pt, 16'h0000};
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] data;
    logic [3:0]  ptype;
  } cmd_t;

  logic [15:0] m_i [INT_REGS];
  logic [15:0] m_f [FP_REGS];
  logic [15:0] m_v [VEC_REGS][4];
  bit          m_prim;
  int          m_vc;
  logic [3:0]  m_err;
  cmd_t        m_q[$];

  task automatic model_reset();
    foreach (m_i[k]) m_i[k] = '0;
    foreach (m_f[k]) m_f[k] = '0;
    foreach (m_v[k, l]) m_v[k][l] = '0;
    m_prim = 0; m_vc = 0; m_err = '0;
    m_q.delete();
  endtask

  task automatic model_exec(input logic [31:0] ins);
    int op, rd, ra, rb, fd, fa, fb, vd, vs, lane;
    logic [15:0] imm, src;
    op = int'(ins[31:24]);
    rd = int'(ins[23:20]) % INT_REGS; ra = int'(ins[19:16]) % INT_REGS; rb = int'(ins[15:12]) % INT_REGS;
    fd = int'(ins[23:20]) % FP_REGS;  fa = int'(ins[19:16]) % FP_REGS;  fb = int'(ins[15:12]) % FP_REGS;
    vd = int'(ins[21:16]) % VEC_REGS; vs = int'(ins[13:8]) % VEC_REGS;  lane = int'(ins[23:22]);
    imm = ins[15:0];
    src = ins[15] ? m_f[int'(ins[11:8]) % FP_REGS] : m_i[int'(ins[11:8]) % INT_REGS];
    case (op)
      8'h01: m_i[rd] = m_i[ra] + m_i[rb];
      8'h02: m_i[rd] = m_i[ra] - m_i[rb];
      8'h03: m_i[rd] = m_i[ra] + imm;
      8'h04: m_i[rd] = m_i[ra] - imm;
      8'h05: m_f[fd] = m_f[fa] + m_f[fb];
      8'h06: m_f[fd] = m_f[fa] - m_f[fb];
      8'h07: m_f[fd] = m_f[fa] + imm;
      8'h08: m_f[fd] = m_f[fa] - imm;
      8'h09: m_i[rd] = m_i[ra];
      8'h0A: m_i[rd] = imm;
      8'h0B: m_f[fd] = imm;
      8'h0C: begin
        logic [15:0] tmp [4];
        for (int l = 0; l < 4; l++) tmp[l] = m_v[vs][l];
        for (int l = 0; l < 4; l++) m_v[vd][l] = tmp[l];
      end
      8'h0D: for (int l = 0; l < 4; l++) m_v[vd][l] = imm;
      8'h0E: m_v[vd][lane] = src;
      8'h0F: m_v[vd][lane] = imm;
      8'h10: if (m_prim) m_err[0] = 1'b1;
             else begin m_prim = 1; m_vc = 0; m_q.push_back('{2'd1, 32'h0, ins[19:16]}); end
      8'h11: if (!m_prim) m_err[1] = 1'b1;
             else begin m_prim = 0; m_q.push_back('{2'd2, 32'h0, 4'h0}); end
      8'h12: if (!m_prim) m_err[2] = 1'b1;
             else begin
               if (m_vc < 255) m_vc++;
               m_q.push_back('{2'd0, {m_v[vd][2], m_v[vd][1]}, 4'h0});
             end
      8'h13: m_q.push_back('{2'd3, 32'h0, 4'h0});
      default: if (op < 8'h20 || op > 8'h29) m_err[3] = 1'b1;
    endcase
  endtask

  // One clock: check the pre-edge view, advance the model, check post-edge state.
  task automatic tick();
    logic exp_ready;
    #1;
    exp_ready = (m_q.size() == 0) || OUT_READY;
    chk("in_ready", IN_READY, exp_ready);
    chk("out_valid", OUT_VALID, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("out_cmd", OUT_CMD, m_q[0].cmd);
      chk("out_data", OUT_DATA, m_q[0].data);
      chk("out_ptype", OUT_PTYPE, m_q[0].ptype);
      if (OUT_READY) void'(m_q.pop_front());
    end
    if (IN_VALID && exp_ready) model_exec(INSTR);
    @(posedge CLK);
    @(negedge CLK);
    chk("prim_active", PRIM_ACTIVE, m_prim);
    chk("vertex_count", VERTEX_COUNT, m_vc);
    chk("err", ERR, m_err);
  endtask

  task automatic reset_dut();
    IN_VALID = 1'b0; OUT_READY = 1'b0; INSTR = '0;
    RESET_N = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;
    logic        exp_ov;
    logic [1:0]  exp_cmd;
    logic [31:0] exp_data;
    logic [3:0]  exp_ptype;
    logic        exp_prim;
    logic [7:0]  exp_vc;
  } vec_t;

  vec_t tbl [15];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, i_rri(8'h0A, 4'd1, 4'd0, 16'h0005), 1, 0, 2'd0, 32'h0, 4'h0, 0, 8'd0};
    tbl[1]  = '{1, i_rri(8'h03, 4'd2, 4'd1, 16'h0003), 1, 0, 2'd0, 32'h0, 4'h0, 0, 8'd0};
    tbl[2]  = '{1, i_rri(8'h09, 4'd3, 4'd2, 16'h0000), 1, 0, 2'd0, 32'h0, 4'h0, 0, 8'd0};
    tbl[3]  = '{1, i_vi(8'h0D, 2'd0, 6'd4, 16'h0010), 1, 0, 2'd0, 32'h0, 4'h0, 0, 8'd0};
    tbl[4]  = '{1, i_vi(8'h0F, 2'd2, 6'd4, 16'h0020), 1, 0, 2'd0, 32'h0, 4'h0, 0, 8'd0};
    tbl[5]  = '{1, i_start(4'd3), 1, 1, 2'd1, 32'h0, 4'h3, 1, 8'd0};
    tbl[6]  = '{1, i_vi(8'h12, 2'd0, 6'd4, 16'h0), 1, 1, 2'd0, 32'h0020_0010, 4'h0, 1, 8'd1};
    tbl[7]  = '{1, i_vr(8'h0E, 2'd1, 6'd5, 1'b0, 4'd3), 1, 0, 2'd0, 32'h0, 4'h0, 1, 8'd1};
    tbl[8]  = '{1, i_rri(8'h0B, 4'd2, 4'd0, 16'h0007), 1, 0, 2'd0, 32'h0, 4'h0, 1, 8'd1};
    tbl[9]  = '{1, i_rri(8'h07, 4'd3, 4'd2, 16'hFFFF), 1, 0, 2'd0, 32'h0, 4'h0, 1, 8'd1};
    tbl[10] = '{1, i_vr(8'h0E, 2'd2, 6'd5, 1'b1, 4'd3), 1, 0, 2'd0, 32'h0, 4'h0, 1, 8'd1};
    tbl[11] = '{1, i_vi(8'h12, 2'd0, 6'd5, 16'h0), 1, 1, 2'd0, 32'h0006_0008, 4'h0, 1, 8'd2};
    tbl[12] = '{1, {8'h11, 24'h0}, 1, 1, 2'd2, 32'h0, 4'h0, 0, 8'd2};
    tbl[13] = '{1, {8'h13, 24'h0}, 1, 1, 2'd3, 32'h0, 4'h0, 0, 8'd2};
    tbl[14] = '{0, 32'h0, 1, 0, 2'd0, 32'h0, 4'h0, 0, 8'd2};

    reset_dut();
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_cmd", OUT_CMD, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_out_ptype", OUT_PTYPE, 0);
    chk("rst_prim", PRIM_ACTIVE, 0);
    chk("rst_vc", VERTEX_COUNT, 0);
    chk("rst_err", ERR, 0);
    @(negedge CLK);

    for (int k = 0; k < 15; k++) begin
      IN_VALID = tbl[k].in_valid; INSTR = tbl[k].instr; OUT_READY = tbl[k].out_ready;
      #1;
      chk("tbl_in_ready", IN_READY, 1);
      tick();
      chk("tbl_out_valid", OUT_VALID, tbl[k].exp_ov);
      if (tbl[k].exp_ov) begin
        chk("tbl_out_cmd", OUT_CMD, tbl[k].exp_cmd);
        chk("tbl_out_data", OUT_DATA, tbl[k].exp_data);
        chk("tbl_out_ptype", OUT_PTYPE, tbl[k].exp_ptype);
      end
      chk("tbl_prim", PRIM_ACTIVE, tbl[k].exp_prim);
      chk("tbl_vc", VERTEX_COUNT, tbl[k].exp_vc);
    end

    // Back-pressure: START loads, DRAWs queue behind it.
    reset_dut();
    IN_VALID = 1; INSTR = i_start(4'd5); OUT_READY = 0;
    tick();
    INSTR = {8'h13, 24'h0};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_in_ready_low", IN_READY, 0);
      chk("bp_hold_cmd", OUT_CMD, 1);
      chk("bp_hold_ptype", OUT_PTYPE, 5);
    end
    OUT_READY = 1;
    tick();
    OUT_READY = 0;
    chk("bp_next_valid", OUT_VALID, 1);
    chk("bp_next_cmd", OUT_CMD, 3);
    tick();
    chk("bp_one_handover", OUT_CMD, 3);
    chk("bp_still_blocked", IN_READY, 0);
    IN_VALID = 0; OUT_READY = 1;
    tick();
    tick();
    IN_VALID = 1; INSTR = {8'h11, 24'h0};
    tick();
    IN_VALID = 0;
    tick();

    // Protocol errors from IDLE.
    reset_dut();
    IN_VALID = 1; OUT_READY = 1;
    INSTR = i_vi(8'h12, 2'd0, 6'd1, 16'h0); tick();
    INSTR = {8'h11, 24'h0};                 tick();
    INSTR = {8'hFF, 24'h0};                 tick();
    IN_VALID = 0;                           tick();
    chk("err_flags", ERR, 4'b1110);
    chk("err_no_out", OUT_VALID, 0);

    // Asynchronous reset while a command is pending inside a primitive.
    IN_VALID = 1; OUT_READY = 0; INSTR = i_start(4'd2);
    tick();
    IN_VALID = 0;
    chk("ar_pre_valid", OUT_VALID, 1);
    chk("ar_pre_prim", PRIM_ACTIVE, 1);
    #2;
    RESET_N = 0;
    #1;
    chk("ar_out_valid", OUT_VALID, 0);
    chk("ar_prim", PRIM_ACTIVE, 0);
    chk("ar_err", ERR, 0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1;

    // Vertex counter saturation.
    IN_VALID = 1; OUT_READY = 1; INSTR = i_start(4'd1);
    tick();
    INSTR = i_vi(8'h12, 2'd0, 6'd0, 16'h0);
    for (int k = 0; k < 260; k++) tick();
    chk("vc_saturate", VERTEX_COUNT, 8'hFF);
    INSTR = {8'h11, 24'h0};
    tick();
    chk("vc_hold_after_end", VERTEX_COUNT, 8'hFF);
    chk("vc_end_idle", PRIM_ACTIVE, 0);

    // Randomized stream against the model.
    for (int k = 0; k < 2500; k++) begin
      int sel;
      logic [7:0] op;
      sel = $urandom_range(0, 99);
      if (sel < 60)      op = 8'($urandom_range(1, 15));
      else if (sel < 85) op = 8'($urandom_range(16, 19));
      else if (sel < 93) op = 8'($urandom_range(32, 41));
      else               op = 8'($urandom_range(0, 255));
      INSTR     = {op, 24'($urandom)};
      IN_VALID  = ($urandom_range(0, 99) < 80);
      OUT_READY = ($urandom_range(0, 99) < 60);
      tick();
    end
    IN_VALID = 0; OUT_READY = 1;
    tick();
    tick();

`ifdef GPU_DECODE_PERF_EN
    reset_dut();
    IN_VALID = 1; INSTR = i_start(4'd0); OUT_READY = 0;
    tick();
    INSTR = {8'h13, 24'h0};
    for (int k = 0; k < 5; k++) tick();
    OUT_READY = 1;
    tick();
    IN_VALID = 0;
    tick();
    OUT_READY = 0;
    tick();
    chk("perf_stall", STALL_CYCLES, 5);
    chk("perf_cmds", CMD_COUNT, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
